// File: rtl/Mem.sv
// Shared line-memory types for the L1 buses and the backing memory port,
// plus the tag and payload types used by the L1 arbiter.
package Mem;

  localparam int LINE_W      = 64;
  localparam int LINEADDR_W  = 26;
  localparam int L1_ARB_ID_W = 2;

  typedef logic [LINEADDR_W-1:0] lineaddr_t;
  typedef logic [LINE_W-1:0]     line_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_e;

  // id carries the downstream tag {src, upstream id}
  typedef struct packed {
    logic [L1_ARB_ID_W:0] id;
    logic                 we;
    lineaddr_t            addr;
    line_t                data;
  } l1_arb_req_t;

  typedef struct packed {
    logic [L1_ARB_ID_W-1:0] id;
    line_t                  data;
  } l1_arb_resp_t;

endpackage

// File: rtl/mem_pipe_reg.sv
// One-entry valid/ready pipeline register with a typed payload.
// Accepts a new beat whenever it is empty or draining in the same cycle.
module mem_pipe_reg #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);

  logic valid_q, valid_d;
  T     data_q, data_d;
  logic load_en;

  always_comb begin
    load_en = !valid_q || out_ready_i;
    valid_d = valid_q;
    data_d  = data_q;
    if (load_en) begin
      valid_d = in_valid_i;
      if (in_valid_i) data_d = in_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready_o  = load_en;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/l1_mem_arbiter.sv
// Round-robin 2:1 arbiter merging the I and D L1 line buses onto one memory
// port; requests are tagged with their source bit and responses steered back.
module l1_mem_arbiter
  import Mem::*;
#(
  parameter int ID_W = Mem::L1_ARB_ID_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req_valid,
  output logic            i_req_ready,
  input  logic [ID_W-1:0] i_req_id,
  input  logic            i_req_we,
  input  lineaddr_t       i_req_addr,
  input  line_t           i_req_data,
  output logic            i_resp_valid,
  input  logic            i_resp_ready,
  output logic [ID_W-1:0] i_resp_id,
  output line_t           i_resp_data,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic [ID_W-1:0] d_req_id,
  input  logic            d_req_we,
  input  lineaddr_t       d_req_addr,
  input  line_t           d_req_data,
  output logic            d_resp_valid,
  input  logic            d_resp_ready,
  output logic [ID_W-1:0] d_resp_id,
  output line_t           d_resp_data,
  output logic            m_req_valid,
  input  logic            m_req_ready,
  output logic [ID_W:0]   m_req_id,
  output logic            m_req_we,
  output lineaddr_t       m_req_addr,
  output line_t           m_req_data,
  input  logic            m_resp_valid,
  output logic            m_resp_ready,
  input  logic [ID_W:0]   m_resp_id,
  input  line_t           m_resp_data
);

  src_e         last_grant_q, last_grant_d;
  logic         req_load_en;
  logic         grant_i, grant_d;
  l1_arb_req_t  req_in, req_out;

  logic         resp_tgt_d;
  logic         i_resp_in_ready, d_resp_in_ready;
  l1_arb_resp_t resp_in, i_resp_out, d_resp_out;

  always_comb begin
    grant_i      = i_req_valid && (!d_req_valid || last_grant_q == SRC_D);
    grant_d      = d_req_valid && !grant_i;
    i_req_ready  = req_load_en && grant_i;
    d_req_ready  = req_load_en && grant_d;

    // the source bit of the tag is simply which port won
    req_in.id    = {grant_d, grant_d ? d_req_id : i_req_id};
    req_in.we    = grant_d ? d_req_we   : i_req_we;
    req_in.addr  = grant_d ? d_req_addr : i_req_addr;
    req_in.data  = grant_d ? d_req_data : i_req_data;

    last_grant_d = last_grant_q;
    if (i_req_ready)      last_grant_d = SRC_I;
    else if (d_req_ready) last_grant_d = SRC_D;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant_q <= SRC_D;
    else      last_grant_q <= last_grant_d;
  end

  mem_pipe_reg #(.T(l1_arb_req_t)) u_req_reg (
    .clk        (clk),
    .rst_n      (rst),
    .in_valid_i (grant_i || grant_d),
    .in_ready_o (req_load_en),
    .in_data_i  (req_in),
    .out_valid_o(m_req_valid),
    .out_ready_i(m_req_ready),
    .out_data_o (req_out)
  );

  assign m_req_id   = req_out.id;
  assign m_req_we   = req_out.we;
  assign m_req_addr = req_out.addr;
  assign m_req_data = req_out.data;

  always_comb begin
    resp_tgt_d   = m_resp_id[ID_W];
    resp_in.id   = m_resp_id[ID_W-1:0];
    resp_in.data = m_resp_data;
    m_resp_ready = resp_tgt_d ? d_resp_in_ready : i_resp_in_ready;
  end

  mem_pipe_reg #(.T(l1_arb_resp_t)) u_i_resp_reg (
    .clk        (clk),
    .rst_n      (rst),
    .in_valid_i (m_resp_valid && !resp_tgt_d),
    .in_ready_o (i_resp_in_ready),
    .in_data_i  (resp_in),
    .out_valid_o(i_resp_valid),
    .out_ready_i(i_resp_ready),
    .out_data_o (i_resp_out)
  );

  mem_pipe_reg #(.T(l1_arb_resp_t)) u_d_resp_reg (
    .clk        (clk),
    .rst_n      (rst),
    .in_valid_i (m_resp_valid && resp_tgt_d),
    .in_ready_o (d_resp_in_ready),
    .in_data_i  (resp_in),
    .out_valid_o(d_resp_valid),
    .out_ready_i(d_resp_ready),
    .out_data_o (d_resp_out)
  );

  assign i_resp_id   = i_resp_out.id;
  assign i_resp_data = i_resp_out.data;
  assign d_resp_id   = d_resp_out.id;
  assign d_resp_data = d_resp_out.data;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Scoreboard bench for l1_mem_arbiter: expected requests/responses are queued
// when driven and popped when the DUT presents them.
module tb_l1_mem_arbiter;
  import Mem::*;

  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_req_valid, i_req_ready, i_req_we;
  logic [ID_W-1:0] i_req_id;
  lineaddr_t       i_req_addr;
  line_t           i_req_data;
  logic            i_resp_valid, i_resp_ready;
  logic [ID_W-1:0] i_resp_id;
  line_t           i_resp_data;
  logic            d_req_valid, d_req_ready, d_req_we;
  logic [ID_W-1:0] d_req_id;
  lineaddr_t       d_req_addr;
  line_t           d_req_data;
  logic            d_resp_valid, d_resp_ready;
  logic [ID_W-1:0] d_resp_id;
  line_t           d_resp_data;
  logic            m_req_valid, m_req_ready, m_req_we;
  logic [ID_W:0]   m_req_id;
  lineaddr_t       m_req_addr;
  line_t           m_req_data;
  logic            m_resp_valid, m_resp_ready;
  logic [ID_W:0]   m_resp_id;
  line_t           m_resp_data;

  int n_pass  = 0;
  int n_total = 0;

  l1_arb_req_t  req_q[$];
  l1_arb_resp_t iresp_q[$];
  l1_arb_resp_t dresp_q[$];
  src_e         model_last;

  always #5 clk = ~clk;

  l1_mem_arbiter #(.ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_id(i_req_id),
    .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready),
    .i_resp_id(i_resp_id), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_id(d_req_id),
    .d_req_we(d_req_we), .d_req_addr(d_req_addr), .d_req_data(d_req_data),
    .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
    .d_resp_id(d_resp_id), .d_resp_data(d_resp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_id(m_req_id),
    .m_req_we(m_req_we), .m_req_addr(m_req_addr), .m_req_data(m_req_data),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
    .m_resp_id(m_resp_id), .m_resp_data(m_resp_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req_valid = 1'b0; i_req_id = '0; i_req_we = 1'b0; i_req_addr = '0; i_req_data = '0;
    d_req_valid = 1'b0; d_req_id = '0; d_req_we = 1'b0; d_req_addr = '0; d_req_data = '0;
    i_resp_ready = 1'b1; d_resp_ready = 1'b1;
    m_req_ready = 1'b1; m_resp_valid = 1'b0; m_resp_id = '0; m_resp_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    #12;
    n_total++; if (m_req_valid !== 1'b0) $display("FAIL reset_m_req_valid: got %b want 0", m_req_valid); else n_pass++;
    n_total++; if (i_resp_valid !== 1'b0) $display("FAIL reset_i_resp_valid: got %b want 0", i_resp_valid); else n_pass++;
    n_total++; if (d_resp_valid !== 1'b0) $display("FAIL reset_d_resp_valid: got %b want 0", d_resp_valid); else n_pass++;
    n_total++; if (m_req_id !== 3'b000) $display("FAIL reset_m_req_id: got %b want 000", m_req_id); else n_pass++;
    n_total++; if (i_resp_data !== '0) $display("FAIL reset_i_resp_data: got %h want 0", i_resp_data); else n_pass++;
    model_last = SRC_D;
    @(negedge clk);
    rst = 1'b1;
    step();
    n_total++; if (m_req_valid !== 1'b0) $display("FAIL post_reset_m_req_valid: got %b want 0", m_req_valid); else n_pass++;
  endtask

  task automatic test_single_read();
    l1_arb_req_t  e;
    l1_arb_resp_t r;
    i_req_valid = 1'b1; i_req_id = 2'd2; i_req_we = 1'b0;
    i_req_addr = lineaddr_t'(26'h10); i_req_data = line_t'(64'h1111);
    m_req_ready = 1'b1;
    #1;
    n_total++; if (i_req_ready !== 1'b1) $display("FAIL single_i_req_ready: got %b want 1", i_req_ready); else n_pass++;
    n_total++; if (d_req_ready !== 1'b0) $display("FAIL single_d_req_ready: got %b want 0", d_req_ready); else n_pass++;
    req_q.push_back('{id: 3'b010, we: 1'b0, addr: lineaddr_t'(26'h10), data: line_t'(64'h1111)});
    model_last = SRC_I;
    step();
    i_req_valid = 1'b0;
    n_total++; if (m_req_valid !== 1'b1) $display("FAIL single_m_req_valid: got %b want 1", m_req_valid); else n_pass++;
    e = req_q.pop_front();
    n_total++; if (m_req_id !== e.id) $display("FAIL single_m_req_id: got %b want %b", m_req_id, e.id); else n_pass++;
    n_total++; if (m_req_addr !== e.addr) $display("FAIL single_m_req_addr: got %h want %h", m_req_addr, e.addr); else n_pass++;
    step();
    n_total++; if (m_req_valid !== 1'b0) $display("FAIL single_m_req_drain: got %b want 0", m_req_valid); else n_pass++;
    m_resp_valid = 1'b1; m_resp_id = 3'b010; m_resp_data = 64'hA5A5_A5A5_A5A5_A5A5;
    i_resp_ready = 1'b1;
    #1;
    n_total++; if (m_resp_ready !== 1'b1) $display("FAIL single_m_resp_ready: got %b want 1", m_resp_ready); else n_pass++;
    iresp_q.push_back('{id: 2'd2, data: 64'hA5A5_A5A5_A5A5_A5A5});
    step();
    m_resp_valid = 1'b0;
    n_total++; if (i_resp_valid !== 1'b1) $display("FAIL single_i_resp_valid: got %b want 1", i_resp_valid); else n_pass++;
    r = iresp_q.pop_front();
    n_total++; if (i_resp_id !== r.id) $display("FAIL single_i_resp_id: got %0d want %0d", i_resp_id, r.id); else n_pass++;
    n_total++; if (i_resp_data !== r.data) $display("FAIL single_i_resp_data: got %h want %h", i_resp_data, r.data); else n_pass++;
    n_total++; if (d_resp_valid !== 1'b0) $display("FAIL single_d_resp_quiet: got %b want 0", d_resp_valid); else n_pass++;
    step();
    n_total++; if (i_resp_valid !== 1'b0) $display("FAIL single_i_resp_drain: got %b want 0", i_resp_valid); else n_pass++;
  endtask

  task automatic test_contention();
    l1_arb_req_t e;
    src_e        exp_src;
    logic [1:0]  iid = 2'd0;
    logic [1:0]  did = 2'd1;
    i_req_valid = 1'b1; d_req_valid = 1'b1; m_req_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      i_req_id = iid; d_req_id = did;
      i_req_addr = lineaddr_t'(c); d_req_addr = lineaddr_t'(26'h100 + c);
      #1;
      exp_src = (model_last == SRC_I) ? SRC_D : SRC_I;
      n_total++; if (i_req_ready !== (exp_src == SRC_I)) $display("FAIL rr_i_req_ready c%0d: got %b want %b", c, i_req_ready, exp_src == SRC_I); else n_pass++;
      n_total++; if (d_req_ready !== (exp_src == SRC_D)) $display("FAIL rr_d_req_ready c%0d: got %b want %b", c, d_req_ready, exp_src == SRC_D); else n_pass++;
      if (exp_src == SRC_D) begin
        req_q.push_back('{id: {1'b1, did}, we: 1'b0, addr: d_req_addr, data: '0});
        did++;
      end else begin
        req_q.push_back('{id: {1'b0, iid}, we: 1'b0, addr: i_req_addr, data: '0});
        iid++;
      end
      model_last = exp_src;
      step();
      n_total++; if (m_req_valid !== 1'b1) $display("FAIL rr_m_req_valid c%0d: got %b want 1", c, m_req_valid); else n_pass++;
      e = req_q.pop_front();
      n_total++; if (m_req_id !== e.id) $display("FAIL rr_m_req_id c%0d: got %b want %b", c, m_req_id, e.id); else n_pass++;
      n_total++; if (m_req_addr !== e.addr) $display("FAIL rr_m_req_addr c%0d: got %h want %h", c, m_req_addr, e.addr); else n_pass++;
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    step();
    n_total++; if (m_req_valid !== 1'b0) $display("FAIL rr_drain: got %b want 0", m_req_valid); else n_pass++;
  endtask

  task automatic test_stall();
    l1_arb_req_t e;
    m_req_ready = 1'b0;
    i_req_valid = 1'b1; i_req_id = 2'd1; i_req_we = 1'b0;
    i_req_addr = lineaddr_t'(26'h30); i_req_data = line_t'(64'h3333);
    #1;
    n_total++; if (i_req_ready !== 1'b1) $display("FAIL stall_fill_ready: got %b want 1", i_req_ready); else n_pass++;
    req_q.push_back('{id: 3'b001, we: 1'b0, addr: lineaddr_t'(26'h30), data: line_t'(64'h3333)});
    model_last = SRC_I;
    step();
    i_req_valid = 1'b0;
    d_req_valid = 1'b1; d_req_id = 2'd2; d_req_we = 1'b1;
    d_req_addr = lineaddr_t'(26'h20); d_req_data = line_t'(64'hDDDD);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_total++; if (d_req_ready !== 1'b0) $display("FAIL stall_d_req_ready c%0d: got %b want 0", c, d_req_ready); else n_pass++;
      n_total++; if (m_req_valid !== 1'b1) $display("FAIL stall_m_req_valid c%0d: got %b want 1", c, m_req_valid); else n_pass++;
      n_total++; if (m_req_id !== req_q[0].id) $display("FAIL stall_m_req_id c%0d: got %b want %b", c, m_req_id, req_q[0].id); else n_pass++;
      n_total++; if (m_req_addr !== req_q[0].addr) $display("FAIL stall_m_req_addr c%0d: got %h want %h", c, m_req_addr, req_q[0].addr); else n_pass++;
      step();
    end
    m_req_ready = 1'b1;
    #1;
    n_total++; if (d_req_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", d_req_ready); else n_pass++;
    e = req_q.pop_front();
    n_total++; if (m_req_data !== e.data) $display("FAIL stall_m_req_data: got %h want %h", m_req_data, e.data); else n_pass++;
    req_q.push_back('{id: 3'b110, we: 1'b1, addr: lineaddr_t'(26'h20), data: line_t'(64'hDDDD)});
    model_last = SRC_D;
    step();
    d_req_valid = 1'b0;
    e = req_q.pop_front();
    n_total++; if (m_req_valid !== 1'b1) $display("FAIL stall_d_m_req_valid: got %b want 1", m_req_valid); else n_pass++;
    n_total++; if (m_req_id !== e.id) $display("FAIL stall_d_m_req_id: got %b want %b", m_req_id, e.id); else n_pass++;
    n_total++; if (m_req_we !== e.we) $display("FAIL stall_d_m_req_we: got %b want %b", m_req_we, e.we); else n_pass++;
    n_total++; if (m_req_addr !== e.addr) $display("FAIL stall_d_m_req_addr: got %h want %h", m_req_addr, e.addr); else n_pass++;
    n_total++; if (m_req_data !== e.data) $display("FAIL stall_d_m_req_data: got %h want %h", m_req_data, e.data); else n_pass++;
    step();
    n_total++; if (m_req_valid !== 1'b0) $display("FAIL stall_drain: got %b want 0", m_req_valid); else n_pass++;
  endtask

  task automatic test_resp_backpressure();
    l1_arb_resp_t r;
    d_resp_ready = 1'b0; i_resp_ready = 1'b1;
    m_resp_valid = 1'b1; m_resp_id = 3'b101; m_resp_data = line_t'(64'hD1);
    #1;
    n_total++; if (m_resp_ready !== 1'b1) $display("FAIL bp_fill_ready: got %b want 1", m_resp_ready); else n_pass++;
    dresp_q.push_back('{id: 2'd1, data: line_t'(64'hD1)});
    step();
    m_resp_id = 3'b111; m_resp_data = line_t'(64'hD2);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_total++; if (m_resp_ready !== 1'b0) $display("FAIL bp_m_resp_ready c%0d: got %b want 0", c, m_resp_ready); else n_pass++;
      n_total++; if (d_resp_valid !== 1'b1) $display("FAIL bp_d_resp_valid c%0d: got %b want 1", c, d_resp_valid); else n_pass++;
      n_total++; if (d_resp_id !== dresp_q[0].id) $display("FAIL bp_d_resp_id c%0d: got %0d want %0d", c, d_resp_id, dresp_q[0].id); else n_pass++;
      step();
    end
    m_resp_id = 3'b001; m_resp_data = line_t'(64'hC1);
    #1;
    n_total++; if (m_resp_ready !== 1'b1) $display("FAIL bp_i_tag_ready: got %b want 1", m_resp_ready); else n_pass++;
    iresp_q.push_back('{id: 2'd1, data: line_t'(64'hC1)});
    step();
    m_resp_id = 3'b111; m_resp_data = line_t'(64'hD2);
    r = iresp_q.pop_front();
    n_total++; if (i_resp_valid !== 1'b1) $display("FAIL bp_i_resp_valid: got %b want 1", i_resp_valid); else n_pass++;
    n_total++; if (i_resp_data !== r.data) $display("FAIL bp_i_resp_data: got %h want %h", i_resp_data, r.data); else n_pass++;
    #1;
    n_total++; if (m_resp_ready !== 1'b0) $display("FAIL bp_still_blocked: got %b want 0", m_resp_ready); else n_pass++;
    d_resp_ready = 1'b1;
    #1;
    n_total++; if (m_resp_ready !== 1'b1) $display("FAIL bp_drain_ready: got %b want 1", m_resp_ready); else n_pass++;
    r = dresp_q.pop_front();
    n_total++; if (d_resp_data !== r.data) $display("FAIL bp_d_first_data: got %h want %h", d_resp_data, r.data); else n_pass++;
    dresp_q.push_back('{id: 2'd3, data: line_t'(64'hD2)});
    step();
    m_resp_valid = 1'b0;
    r = dresp_q.pop_front();
    n_total++; if (d_resp_valid !== 1'b1) $display("FAIL bp_d_second_valid: got %b want 1", d_resp_valid); else n_pass++;
    n_total++; if (d_resp_id !== r.id) $display("FAIL bp_d_second_id: got %0d want %0d", d_resp_id, r.id); else n_pass++;
    n_total++; if (d_resp_data !== r.data) $display("FAIL bp_d_second_data: got %h want %h", d_resp_data, r.data); else n_pass++;
    step();
    n_total++; if (d_resp_valid !== 1'b0) $display("FAIL bp_d_drain: got %b want 0", d_resp_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    l1_arb_resp_t r;
    i_resp_ready = 1'b1;
    m_resp_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m_resp_id = {1'b0, 2'(k)};
      m_resp_data = line_t'(64'hB0 + k);
      #1;
      n_total++; if (m_resp_ready !== 1'b1) $display("FAIL b2b_m_resp_ready k%0d: got %b want 1", k, m_resp_ready); else n_pass++;
      iresp_q.push_back('{id: 2'(k), data: line_t'(64'hB0 + k)});
      step();
      r = iresp_q.pop_front();
      n_total++; if (i_resp_valid !== 1'b1) $display("FAIL b2b_i_resp_valid k%0d: got %b want 1", k, i_resp_valid); else n_pass++;
      n_total++; if (i_resp_id !== r.id) $display("FAIL b2b_i_resp_id k%0d: got %0d want %0d", k, i_resp_id, r.id); else n_pass++;
      n_total++; if (i_resp_data !== r.data) $display("FAIL b2b_i_resp_data k%0d: got %h want %h", k, i_resp_data, r.data); else n_pass++;
    end
    m_resp_valid = 1'b0;
    step();
    n_total++; if (i_resp_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", i_resp_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    m_req_ready = 1'b0;
    i_req_valid = 1'b1; i_req_id = 2'd3; i_req_addr = lineaddr_t'(26'h40);
    d_resp_ready = 1'b0;
    m_resp_valid = 1'b1; m_resp_id = 3'b110; m_resp_data = line_t'(64'hEE);
    step();
    i_req_valid = 1'b0; m_resp_valid = 1'b0;
    n_total++; if (m_req_valid !== 1'b1) $display("FAIL rstmid_pre_m_req_valid: got %b want 1", m_req_valid); else n_pass++;
    n_total++; if (d_resp_valid !== 1'b1) $display("FAIL rstmid_pre_d_resp_valid: got %b want 1", d_resp_valid); else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_total++; if (m_req_valid !== 1'b0) $display("FAIL rstmid_m_req_valid: got %b want 0", m_req_valid); else n_pass++;
    n_total++; if (d_resp_valid !== 1'b0) $display("FAIL rstmid_d_resp_valid: got %b want 0", d_resp_valid); else n_pass++;
    n_total++; if (i_resp_valid !== 1'b0) $display("FAIL rstmid_i_resp_valid: got %b want 0", i_resp_valid); else n_pass++;
    req_q.delete(); iresp_q.delete(); dresp_q.delete();
    model_last = SRC_D;
    @(negedge clk);
    rst = 1'b1;
    m_req_ready = 1'b1; d_resp_ready = 1'b1;
    i_req_valid = 1'b1; i_req_id = 2'd0;
    d_req_valid = 1'b1; d_req_id = 2'd1;
    #1;
    n_total++; if (i_req_ready !== 1'b1) $display("FAIL rstmid_tie_i_ready: got %b want 1", i_req_ready); else n_pass++;
    n_total++; if (d_req_ready !== 1'b0) $display("FAIL rstmid_tie_d_ready: got %b want 0", d_req_ready); else n_pass++;
    step();
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    n_total++; if (m_req_id !== 3'b000) $display("FAIL rstmid_tie_m_req_id: got %b want 000", m_req_id); else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_stall();
    test_resp_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
